// File: rtl/load_store_unit.sv
// Per-thread load/store unit: latches one LDR/STR per REQUEST phase, runs a single
// valid/ready transaction to the memory controller and exposes its state to the scheduler.
module load_store_unit #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 mem_read_enable,
  input  logic                 mem_write_enable,
  input  logic [DATA_BITS-1:0] rs_data,
  input  logic [DATA_BITS-1:0] rt_data,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready,
  output logic [1:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out
);

  localparam logic [2:0] CoreRequest = 3'b011;
  localparam logic [2:0] CoreUpdate  = 3'b110;

  typedef enum logic [1:0] {
    StIdle       = 2'b00,
    StRequesting = 2'b01,
    StWaiting    = 2'b10,
    StDone       = 2'b11
  } state_e;

  state_e               state_q, state_d;
  logic                 is_read_q, is_read_d;
  logic                 read_valid_q, read_valid_d;
  logic [ADDR_BITS-1:0] read_addr_q, read_addr_d;
  logic                 write_valid_q, write_valid_d;
  logic [ADDR_BITS-1:0] write_addr_q, write_addr_d;
  logic [DATA_BITS-1:0] write_data_q, write_data_d;
  logic [DATA_BITS-1:0] out_q, out_d;

  always_comb begin
    state_d       = state_q;
    is_read_d     = is_read_q;
    read_valid_d  = read_valid_q;
    read_addr_d   = read_addr_q;
    write_valid_d = write_valid_q;
    write_addr_d  = write_addr_q;
    write_data_d  = write_data_q;
    out_d         = out_q;

    if (enable) begin
      unique case (state_q)
        StIdle: begin
          // Read takes priority when both decodes are asserted.
          if (core_state == CoreRequest && (mem_read_enable || mem_write_enable)) begin
            state_d   = StRequesting;
            is_read_d = mem_read_enable;
          end
        end
        StRequesting: begin
          state_d = StWaiting;
          if (is_read_q) begin
            read_valid_d = 1'b1;
            read_addr_d  = rs_data[ADDR_BITS-1:0];
          end else begin
            write_valid_d = 1'b1;
            write_addr_d  = rs_data[ADDR_BITS-1:0];
            write_data_d  = rt_data;
          end
        end
        StWaiting: begin
          if (is_read_q && mem_read_ready) begin
            out_d        = mem_read_data;
            read_valid_d = 1'b0;
            state_d      = StDone;
          end else if (!is_read_q && mem_write_ready) begin
            write_valid_d = 1'b0;
            state_d       = StDone;
          end
        end
        StDone: begin
          if (core_state == CoreUpdate) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      is_read_q     <= 1'b0;
      read_valid_q  <= 1'b0;
      read_addr_q   <= '0;
      write_valid_q <= 1'b0;
      write_addr_q  <= '0;
      write_data_q  <= '0;
      out_q         <= '0;
    end else begin
      state_q       <= state_d;
      is_read_q     <= is_read_d;
      read_valid_q  <= read_valid_d;
      read_addr_q   <= read_addr_d;
      write_valid_q <= write_valid_d;
      write_addr_q  <= write_addr_d;
      write_data_q  <= write_data_d;
      out_q         <= out_d;
    end
  end

  assign lsu_state         = state_q;
  assign mem_read_valid    = read_valid_q;
  assign mem_read_address  = read_addr_q;
  assign mem_write_valid   = write_valid_q;
  assign mem_write_address = write_addr_q;
  assign mem_write_data    = write_data_q;
  assign lsu_out           = out_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Per-thread load/store unit in the thread datapath. It takes the address and store data from the register file's read ports (`rs_data`, `rt_data`) and runs a valid/ready request to the memory controller. Load data comes back on `lsu_out`, which the register file writes into `rd` during UPDATE. It also reports its own state, so the core scheduler can stall the block until every thread's memory access has finished.

## Interface
Parameters:
- ADDR_BITS, 8, memory address width; the low bits of `rs_data` are used.
- DATA_BITS, 8, memory and register data width.

Ports:
- clock  input  1  clock; all state updates on its rising edge.
- reset  input  1  reset, synchronous, active-high.
- enable  input  1  thread active; low freezes all state and outputs (reset still applies).
- core_state  input  3  core phase: 3'b011 = REQUEST, 3'b110 = UPDATE; other values are ignored.
- mem_read_enable  input  1  decoded LDR instruction.
- mem_write_enable  input  1  decoded STR instruction.
- rs_data  input  DATA_BITS  address operand.
- rt_data  input  DATA_BITS  store data operand.
- mem_read_valid  output  1  read request valid.
- mem_read_address  output  ADDR_BITS  read address.
- mem_read_ready  input  1  read accepted; `mem_read_data` is valid this cycle.
- mem_read_data  input  DATA_BITS  read return data.
- mem_write_valid  output  1  write request valid.
- mem_write_address  output  ADDR_BITS  write address.
- mem_write_data  output  DATA_BITS  write data.
- mem_write_ready  input  1  write accepted.
- lsu_state  output  2  IDLE = 2'b00, REQUESTING = 2'b01, WAITING = 2'b10, DONE = 2'b11.
- lsu_out  output  DATA_BITS  last loaded value.

## Operation
- All outputs are registered. Reset value of every output and of all state is 0; `lsu_state` = IDLE.
- A write is a store and a read is a load. If both `mem_read_enable` and `mem_write_enable` are high, the read wins and the write is ignored for that instruction.
- State transitions, evaluated only when `enable` = 1:
  - IDLE -> REQUESTING when `core_state` = REQUEST and either enable is high. The operation type is latched at this edge. Otherwise the block stays in IDLE.
  - REQUESTING -> WAITING unconditionally. At this edge:
    - Read: `mem_read_valid` <= 1, `mem_read_address` <= `rs_data[ADDR_BITS-1:0]`.
    - Write: `mem_write_valid` <= 1, `mem_write_address` <= `rs_data`, `mem_write_data` <= `rt_data`.
  - WAITING: valid, address and data hold steady until the matching ready is sampled high.
    - Read: `lsu_out` <= `mem_read_data`, `mem_read_valid` <= 0, -> DONE.
    - Write: `mem_write_valid` <= 0, -> DONE.
  - DONE -> IDLE when `core_state` = UPDATE; otherwise hold.
- The ready of the unused channel is ignored, and any ready is ignored outside WAITING.
- `lsu_out` changes only on read completion. Stores and reset-free idle periods leave it unchanged.
- Address and data are sampled once, at the REQUESTING edge. Later changes on `rs_data`/`rt_data` have no effect.
- Address and data outputs keep their last values after valid drops; they are not cleared.

## Timing
- The edge that samples REQUEST is E0.
  - E1: valid rises.
  - Earliest completion: E2, if ready is high in the E1–E2 cycle.
  - `lsu_out` is valid from E2 and `lsu_state` = DONE from E2.
- Each cycle of ready low in WAITING adds one cycle. There is no timeout.
- Valid stays high for at least one full cycle and drops on the edge after ready is sampled high. At most one request is outstanding.
- `enable` low mid-operation: state, valid, address and data hold. The handshake resumes when `enable` returns.
- `reset` mid-operation: on the next edge, valid = 0, `lsu_state` = IDLE, `lsu_out` = 0. Any pending request is abandoned.
- REQUEST seen in WAITING or DONE is ignored. UPDATE seen in IDLE, REQUESTING or WAITING is ignored.

## Test plan
- Load, ready immediately: `rs_data` = 8'h2A, read enable, REQUEST. Required:
  - `mem_read_valid` = 1 with address 8'h2A at E1.
  - With `mem_read_data` = 8'h5C and ready high: `lsu_out` = 8'h5C and `lsu_state` = DONE at E2.
  - UPDATE -> IDLE.
- Store with a 3-cycle ready delay: `rs_data` = 8'h10, `rt_data` = 8'h77. Required:
  - Write valid, address 8'h10 and data 8'h77 hold steady for 3 cycles.
  - Valid drops the edge after ready; `lsu_out` is unchanged.
- Both enables high, `rs_data` = 8'h03. Required: only `mem_read_valid` asserts; `mem_write_valid` stays 0 throughout.
- `rs_data` changed from 8'h04 to 8'hFF after E1, during WAITING. Required: `mem_read_address` stays 8'h04.
- `enable` dropped for 2 cycles in WAITING, with ready pulsed high during that window. Required: no completion; completion occurs only on a ready sampled after `enable` returns.
- `reset` asserted in WAITING with valid high. Required: valid = 0, `lsu_state` = IDLE, `lsu_out` = 0 on the next edge.
